multi_carrier_generator: RTL and testbench

- Parametrised successor of the single 0-phase triangular carrier.
- Generates N_CH phase-shifted triangular carriers from one shared master counter. Each carrier has a runtime-programmable peak and a runtime-programmable per-channel phase.
- Emits a sample strobe (ADC trigger) at peak and/or valley of channel 0.
- Feeds the PWM comparators of the multilevel converter, which needs interleaved carriers.

---
 rtl/multi_carrier_generator.sv | 132 +++++++++++++
 tb/tb_multi_carrier_generator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_carrier_generator.sv
`default_nettype none
// ============================================================================
// Module      : multi_carrier_generator
// Description : N_CH phase-shifted triangular PWM carriers derived from one
//               shared master counter, with shadowed peak/phase registers and
//               an ADC sample strobe on channel 0 peak and/or valley.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               en                - count enable (0 freezes all state)
//               peak_in           - requested carrier peak P (0 treated as 1)
//               phase_in          - per-channel phase, (WIDTH+1) bits each
//               evt_mode          - strobe select: [0] peak, [1] valley
//               count, dir        - per-channel carrier value and slope
//               sample_evt        - one-cycle ADC trigger
//               period_start      - one-cycle pulse when master counter is 0
// Revision    : 1.0 - initial release
// ============================================================================
module multi_carrier_generator #(
    parameter int WIDTH = 7,
    parameter int N_CH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [WIDTH-1:0]           peak_in,
    input  logic [N_CH*(WIDTH+1)-1:0]  phase_in,
    input  logic [1:0]                 evt_mode,
    output logic [N_CH*WIDTH-1:0]      count,
    output logic [N_CH-1:0]            dir,
    output logic                       sample_evt,
    output logic                       period_start
);

    localparam int PH_W  = WIDTH + 1;
    localparam int SUM_W = WIDTH + 2;

    logic [WIDTH-1:0]       p_act_q, p_act_d;
    logic [N_CH*PH_W-1:0]   ph_act_q, ph_act_d;
    logic [PH_W-1:0]        m_q, m_d;
    logic [N_CH*WIDTH-1:0]  count_q, count_d;
    logic [N_CH-1:0]        dir_q, dir_d;
    logic                   sample_evt_q, sample_evt_d;
    logic                   period_start_q, period_start_d;

    logic [WIDTH-1:0]       w_peak_eff;
    logic [PH_W-1:0]        w_period_new;
    logic [PH_W-1:0]        w_period;
    logic [PH_W-1:0]        w_last;
    logic                   w_wrap;
    logic [N_CH*WIDTH-1:0]  w_c;
    logic [N_CH-1:0]        w_dir;
    logic [N_CH*PH_W-1:0]   w_ph_new;

    // Values that would be captured into the shadow registers right now.
    assign w_peak_eff   = (peak_in == '0) ? WIDTH'(1) : peak_in;
    assign w_period_new = {w_peak_eff, 1'b0};

    assign w_period = {p_act_q, 1'b0};
    assign w_last   = w_period - PH_W'(1);
    assign w_wrap   = en && (m_q == w_last);

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_ch
            logic [PH_W-1:0]  w_ph_in;
            logic [PH_W-1:0]  w_ph;
            logic [SUM_W-1:0] w_sum;
            logic [PH_W-1:0]  w_t;

            // Out-of-range phases are validated against the peak being loaded
            // alongside them, not the one currently active.
            assign w_ph_in = phase_in[k*PH_W +: PH_W];
            assign w_ph_new[k*PH_W +: PH_W] = (w_ph_in >= w_period_new) ? '0 : w_ph_in;

            assign w_ph  = ph_act_q[k*PH_W +: PH_W];
            assign w_sum = {1'b0, m_q} + {1'b0, w_ph};
            // Both operands are < 2P, so one conditional subtract folds t into range.
            assign w_t   = (w_sum >= {1'b0, w_period}) ? PH_W'(w_sum - {1'b0, w_period})
                                                       : PH_W'(w_sum);

            assign w_c[k*WIDTH +: WIDTH] = (w_t <= {1'b0, p_act_q}) ? WIDTH'(w_t)
                                                                    : WIDTH'(w_period - w_t);
            assign w_dir[k] = (w_t < {1'b0, p_act_q});
        end
    endgenerate

    always_comb begin
        m_d      = m_q;
        p_act_d  = p_act_q;
        ph_act_d = ph_act_q;
        if (en) begin
            m_d = w_wrap ? '0 : (m_q + PH_W'(1));
            if (w_wrap) begin
                p_act_d  = w_peak_eff;
                ph_act_d = w_ph_new;
            end
        end
    end

    always_comb begin
        count_d        = en ? w_c   : count_q;
        dir_d          = en ? w_dir : dir_q;
        sample_evt_d   = en && ((evt_mode[0] && (w_c[WIDTH-1:0] == p_act_q)) ||
                                (evt_mode[1] && (w_c[WIDTH-1:0] == '0)));
        period_start_d = en && (m_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q            <= '0;
            p_act_q        <= w_peak_eff;
            ph_act_q       <= w_ph_new;
            count_q        <= '0;
            dir_q          <= '1;
            sample_evt_q   <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            m_q            <= m_d;
            p_act_q        <= p_act_d;
            ph_act_q       <= ph_act_d;
            count_q        <= count_d;
            dir_q          <= dir_d;
            sample_evt_q   <= sample_evt_d;
            period_start_q <= period_start_d;
        end
    end

    assign count        = count_q;
    assign dir          = dir_q;
    assign sample_evt   = sample_evt_q;
    assign period_start = period_start_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_carrier_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_carrier_generator
// Description : Directed bench for multi_carrier_generator (WIDTH=7, N_CH=2):
//               a table of single-point vectors taken a fixed number of cycles
//               after reset, plus sequences for period sweep, mid-period peak
//               change, enable hold and mid-period reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_carrier_generator;

    localparam int WIDTH = 7;
    localparam int N_CH  = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      en;
    logic [WIDTH-1:0]          peak_in;
    logic [N_CH*(WIDTH+1)-1:0] phase_in;
    logic [1:0]                evt_mode;
    logic [N_CH*WIDTH-1:0]     count;
    logic [N_CH-1:0]           dir;
    logic                      sample_evt;
    logic                      period_start;

    int checks   = 0;
    int failures = 0;

    multi_carrier_generator #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .peak_in      (peak_in),
        .phase_in     (phase_in),
        .evt_mode     (evt_mode),
        .count        (count),
        .dir          (dir),
        .sample_evt   (sample_evt),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  peak;
        logic [7:0]  ph0;
        logic [7:0]  ph1;
        logic [1:0]  mode;
        logic [15:0] n;      // enabled edges after reset release
        logic [6:0]  e_c0;
        logic [6:0]  e_c1;
        logic [1:0]  e_dir;  // {dir1, dir0}
        logic        e_evt;
        logic        e_ps;
    } vec_t;

    vec_t vecs [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0d expected=%0d", nm, idx, act, exp);
        end
    endtask

    task automatic do_reset(input logic [6:0] pk, input logic [7:0] p0,
                            input logic [7:0] p1, input logic [1:0] md);
        rst      = 1'b1;
        en       = 1'b1;
        peak_in  = pk;
        phase_in = {p1, p0};
        evt_mode = md;
        step();
        rst = 1'b0;
    endtask

    function automatic int tri127(input int m);
        return (m <= 127) ? m : 254 - m;
    endfunction

    initial begin
        int bad, nevt, nps, first_ps, mx;
        int c0, c1;

        rst = 1'b1; en = 1'b0; peak_in = '0; phase_in = '0; evt_mode = '0;

        //            peak  ph0   ph1   mode   n     c0   c1   dir   evt  ps
        vecs[0]  = '{7'd127, 8'd0, 8'd127, 2'b01, 16'd1,   7'd0,   7'd127, 2'b01, 1'b0, 1'b1};
        vecs[1]  = '{7'd127, 8'd0, 8'd127, 2'b01, 16'd128, 7'd127, 7'd0,   2'b10, 1'b1, 1'b0};
        vecs[2]  = '{7'd127, 8'd0, 8'd127, 2'b01, 16'd129, 7'd126, 7'd1,   2'b10, 1'b0, 1'b0};
        vecs[3]  = '{7'd127, 8'd0, 8'd127, 2'b01, 16'd255, 7'd0,   7'd127, 2'b01, 1'b0, 1'b1};
        vecs[4]  = '{7'd10,  8'd0, 8'd5,   2'b11, 16'd11,  7'd10,  7'd5,   2'b00, 1'b1, 1'b0};
        vecs[5]  = '{7'd10,  8'd0, 8'd5,   2'b11, 16'd21,  7'd0,   7'd5,   2'b11, 1'b1, 1'b1};
        vecs[6]  = '{7'd10,  8'd0, 8'd5,   2'b11, 16'd16,  7'd5,   7'd0,   2'b10, 1'b0, 1'b0};
        vecs[7]  = '{7'd0,   8'd0, 8'd0,   2'b11, 16'd2,   7'd1,   7'd1,   2'b00, 1'b1, 1'b0};
        vecs[8]  = '{7'd0,   8'd0, 8'd0,   2'b11, 16'd3,   7'd0,   7'd0,   2'b11, 1'b1, 1'b1};
        vecs[9]  = '{7'd127, 8'd0, 8'd255, 2'b01, 16'd50,  7'd49,  7'd49,  2'b11, 1'b0, 1'b0};
        vecs[10] = '{7'd5,   8'd12,8'd9,   2'b10, 16'd1,   7'd0,   7'd1,   2'b01, 1'b1, 1'b1};
        vecs[11] = '{7'd5,   8'd3, 8'd0,   2'b01, 16'd3,   7'd5,   7'd2,   2'b10, 1'b1, 1'b0};

        for (int i = 0; i < 12; i++) begin
            do_reset(vecs[i].peak, vecs[i].ph0, vecs[i].ph1, vecs[i].mode);
            if (i == 0) begin
                chk("rst_count", i, int'(count), 0);
                chk("rst_dir", i, int'(dir), 3);
                chk("rst_evt", i, int'(sample_evt), 0);
                chk("rst_ps", i, int'(period_start), 0);
            end
            for (int j = 0; j < int'(vecs[i].n); j++) step();
            chk("vec_c0",  i, int'(count[6:0]),  int'(vecs[i].e_c0));
            chk("vec_c1",  i, int'(count[13:7]), int'(vecs[i].e_c1));
            chk("vec_dir", i, int'(dir),         int'(vecs[i].e_dir));
            chk("vec_evt", i, int'(sample_evt),  int'(vecs[i].e_evt));
            chk("vec_ps",  i, int'(period_start),int'(vecs[i].e_ps));
        end

        // Two full periods at P=127, phases {127,0}: triangle, inverse, pulse counts.
        do_reset(7'd127, 8'd0, 8'd127, 2'b01);
        bad = 0; nevt = 0; nps = 0;
        for (int i = 1; i <= 508; i++) begin
            step();
            c0 = int'(count[6:0]);
            c1 = int'(count[13:7]);
            if (c0 != tri127((i - 1) % 254)) bad++;
            if (c1 != 127 - c0) bad++;
            if (sample_evt) begin
                nevt++;
                if (c0 != 127) bad++;
            end
            if (period_start) nps++;
        end
        chk("sweep_errs", 0, bad, 0);
        chk("sweep_evt", 0, nevt, 2);
        chk("sweep_ps", 0, nps, 2);

        // Peak changed 127 -> 50 at m = 100: takes effect only at the wrap.
        do_reset(7'd127, 8'd0, 8'd0, 2'b01);
        for (int i = 0; i < 101; i++) step();
        chk("chg_at_m100", 0, int'(count[6:0]), 100);
        peak_in = 7'd50;
        first_ps = -1; mx = 0; bad = 0;
        for (int i = 1; i <= 154; i++) begin
            step();
            if (int'(count[6:0]) > mx) mx = int'(count[6:0]);
            if (int'(count[6:0]) != tri127(100 + i) && i < 154) bad++;
            if (period_start && first_ps < 0) first_ps = i;
        end
        chk("chg_old_ps", 0, first_ps, 154);
        chk("chg_old_max", 0, mx, 127);
        chk("chg_old_errs", 0, bad, 0);
        first_ps = -1; mx = 0; bad = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (int'(count[6:0]) > mx) mx = int'(count[6:0]);
            if (int'(count[6:0]) != ((i % 100) <= 50 ? (i % 100) : 100 - i)) bad++;
            if (period_start && first_ps < 0) first_ps = i;
        end
        chk("chg_new_ps", 0, first_ps, 100);
        chk("chg_new_max", 0, mx, 50);
        chk("chg_new_errs", 0, bad, 0);

        // Enable low for 5 cycles at ch0 = 40 rising.
        do_reset(7'd127, 8'd0, 8'd0, 2'b11);
        for (int i = 0; i < 41; i++) step();
        chk("hold_pre", 0, int'(count[6:0]), 40);
        en = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (count[6:0] != 7'd40 || dir[0] != 1'b1 || sample_evt || period_start) bad++;
        end
        chk("hold_errs", 0, bad, 0);
        en = 1'b1;
        step();
        chk("hold_resume", 0, int'(count[6:0]), 41);
        chk("hold_resume_dir", 0, int'(dir[0]), 1);

        // Reset at ch0 = 90 falling, with new peak/phase presented during reset.
        do_reset(7'd127, 8'd0, 8'd127, 2'b01);
        for (int i = 0; i < 165; i++) step();
        chk("mrst_pre", 0, int'(count[6:0]), 90);
        chk("mrst_pre_dir", 0, int'(dir[0]), 0);
        rst = 1'b1; peak_in = 7'd20; phase_in = {8'd10, 8'd0};
        step();
        rst = 1'b0;
        chk("mrst_count", 0, int'(count), 0);
        chk("mrst_evt", 0, int'(sample_evt), 0);
        step();
        chk("mrst_c0", 0, int'(count[6:0]), 0);
        chk("mrst_c1", 0, int'(count[13:7]), 10);
        chk("mrst_ps", 0, int'(period_start), 1);
        for (int i = 0; i < 20; i++) step();
        chk("mrst_peak_c0", 0, int'(count[6:0]), 20);
        chk("mrst_peak_evt", 0, int'(sample_evt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
